serial_subtractor: RTL

- Bit-serial N-bit subtractor; computes diff = a - b, LSB first, one bit per clock.
- Uses a single full-subtractor cell (d = x^y^br; br' = (~x&y) | (~(x^y)&br)) and a borrow flip-flop.
- Inverse-operation counterpart to the team's combinational adder cells; gives a small sequential arithmetic datapath with a start/done handshake.

---
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor.sv | 129 ++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master issues start with operands; the slave returns status and the held result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, ovf, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, ovf, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, using one full-subtractor cell and a borrow flop.
// Results are published only on the SHIFT->DONE edge and held until the next one.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] r_sh_reg;
    logic [WIDTH-1:0] diff_reg;
    logic [CW-1:0]    cnt_reg;
    logic             br_reg;
    logic             a_msb_reg;
    logic             b_msb_reg;
    logic             borrow_reg;
    logic             ovf_reg;
    logic             zero_reg;

    logic             accept;
    logic             last_bit;
    logic             x_bit;
    logic             y_bit;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] r_next;

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        x_bit    = a_sh_reg[0];
        y_bit    = b_sh_reg[0];
        d_bit    = x_bit ^ y_bit ^ br_reg;
        br_next  = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_reg);
        r_next   = {d_bit, r_sh_reg[WIDTH-1:1]};
        last_bit = (cnt_reg == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_bit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = S_SHIFT;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            r_sh_reg   <= '0;
            br_reg     <= 1'b0;
            cnt_reg    <= '0;
            a_msb_reg  <= 1'b0;
            b_msb_reg  <= 1'b0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            ovf_reg    <= 1'b0;
            zero_reg   <= 1'b0;
        end else if (accept) begin
            a_sh_reg  <= bus.a;
            b_sh_reg  <= bus.b;
            r_sh_reg  <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            a_msb_reg <= bus.a[WIDTH-1];
            b_msb_reg <= bus.b[WIDTH-1];
        end else if (state_reg == S_SHIFT) begin
            a_sh_reg <= a_sh_reg >> 1;
            b_sh_reg <= b_sh_reg >> 1;
            r_sh_reg <= r_next;
            br_reg   <= br_next;
            cnt_reg  <= cnt_reg + 1'b1;
            // Publish using the in-flight bit so the result includes the MSB.
            if (last_bit) begin
                diff_reg   <= r_next;
                borrow_reg <= br_next;
                ovf_reg    <= (a_msb_reg != b_msb_reg) && (r_next[WIDTH-1] != a_msb_reg);
                zero_reg   <= (r_next == '0);
            end
        end
    end

    assign bus.busy   = (state_reg == S_SHIFT);
    assign bus.done   = (state_reg == S_DONE);
    assign bus.diff   = diff_reg;
    assign bus.borrow = borrow_reg;
    assign bus.ovf    = ovf_reg;
    assign bus.zero   = zero_reg;

endmodule
